// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared operation encodings for the ALU logic group
//
// Purpose: single source for the opSel width and the eight bitwise
// operation codes, so the stage, the core decoder and any result mux
// upstream agree on the same values.
package alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_XOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_e;

endpackage : alu_pkg

// File: rtl/alu_logic_core.sv
// rtl/alu_logic_core.sv - combinational bitwise operation and status flags
//
// Purpose: evaluates one of eight bitwise operations on two WIDTH-bit
// operands and derives zero / all-ones / parity flags from the result.
// Ports:
//   a_i       in  WIDTH  effective operand A (already chain-selected)
//   b_i       in  WIDTH  operand B (unused by NOT and PASS)
//   op_sel_i  in  OP_W   operation select (alu_pkg::op_e encoding)
//   result_o  out WIDTH  operation result
//   zero_o    out 1      result == 0
//   ones_o    out 1      result == all ones
//   parity_o  out 1      XOR-reduction of result
module alu_logic_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OP_W-1:0]  op_sel_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             ones_o,
  output logic             parity_o
);

  always_comb begin
    result_o = a_i;
    case (op_e'(op_sel_i))
      OP_NOT:  result_o = ~a_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_NAND: result_o = ~(a_i & b_i);
      OP_NOR:  result_o = ~(a_i | b_i);
      OP_XNOR: result_o = ~(a_i ^ b_i);
      OP_PASS: result_o = a_i;
      default: result_o = a_i;
    endcase
  end

  assign zero_o   = ~|result_o;
  assign ones_o   = &result_o;
  assign parity_o = ^result_o;

endmodule : alu_logic_core

// File: rtl/alu_logic_stage.sv
// rtl/alu_logic_stage.sv - registered bitwise ALU stage with handshake, chaining and counter
//
// Purpose: one-deep pipeline register around alu_logic_core. Accepts an
// operand beat on inValid && inReady, presents the registered result and
// flags with outValid until outReady, optionally substitutes the last
// accepted result for operand A, and counts completed output handshakes.
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   inValid/inReady    input beat handshake (inReady is combinational)
//   inA, inB, opSel    operands and operation select
//   chain              1 = use the last accepted result as operand A
//   outValid/outReady  output beat handshake
//   result             registered operation result
//   zeroFlag, onesFlag, parityFlag  flags of the registered result
//   txnCount           completed output handshakes, wrapping
module alu_logic_stage
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inValid,
  output logic               inReady,
  input  logic [WIDTH-1:0]   inA,
  input  logic [WIDTH-1:0]   inB,
  input  logic [OP_W-1:0]    opSel,
  input  logic               chain,
  output logic               outValid,
  input  logic               outReady,
  output logic [WIDTH-1:0]   result,
  output logic               zeroFlag,
  output logic               onesFlag,
  output logic               parityFlag,
  output logic [COUNT_W-1:0] txnCount
);

  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               ones_q, ones_d;
  logic               parity_q, parity_d;
  logic [WIDTH-1:0]   last_q, last_d;
  logic [COUNT_W-1:0] txn_q, txn_d;

  logic               accept;
  logic               complete;
  logic [WIDTH-1:0]   eff_a;
  logic [WIDTH-1:0]   core_result;
  logic               core_zero;
  logic               core_ones;
  logic               core_parity;

  // Ready depends only on the output register state, never on inValid,
  // so an upstream stage may wait for ready before raising valid.
  assign inReady  = !out_valid_q || outReady;
  assign accept   = inValid && inReady;
  assign complete = out_valid_q && outReady;

  // last_q tracks the newest accepted result, which may still be sitting
  // unconsumed in result_q; chaining therefore never waits on downstream.
  assign eff_a = chain ? last_q : inA;

  alu_logic_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a_i      (eff_a),
    .b_i      (inB),
    .op_sel_i (opSel),
    .result_o (core_result),
    .zero_o   (core_zero),
    .ones_o   (core_ones),
    .parity_o (core_parity)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ones_d      = ones_q;
    parity_d    = parity_q;
    last_d      = last_q;
    txn_d       = txn_q;

    if (accept) begin
      // Covers both EMPTY->FULL and FULL->FULL with a simultaneous complete.
      out_valid_d = 1'b1;
      result_d    = core_result;
      zero_d      = core_zero;
      ones_d      = core_ones;
      parity_d    = core_parity;
      last_d      = core_result;
    end else if (complete) begin
      // Result and flags keep their last value once drained.
      out_valid_d = 1'b0;
    end

    if (complete) begin
      txn_d = txn_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      ones_q      <= 1'b0;
      parity_q    <= 1'b0;
      last_q      <= '0;
      txn_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ones_q      <= ones_d;
      parity_q    <= parity_d;
      last_q      <= last_d;
      txn_q       <= txn_d;
    end
  end

  assign outValid   = out_valid_q;
  assign result     = result_q;
  assign zeroFlag   = zero_q;
  assign onesFlag   = ones_q;
  assign parityFlag = parity_q;
  assign txnCount   = txn_q;

endmodule : alu_logic_stage
